led_pulse_stretch: RTL and testbench

Output-side counterpart to the push-button debouncer. It turns single-CLK event pulses (step pulses, halt strobes, carry events) into LED blinks a human can see. Each accepted input pulse produces one blink: LED on for a fixed time, then off for a fixed gap. Pulses that arrive during a blink are queued or dropped, depending on configuration. The block sits between the TD4 core/control logic and the board LED pins.

---
 rtl/led_pulse_stretch_if.sv | 27 ++
 rtl/led_pulse_stretch.sv | 161 ++++++++++++++++
 tb/tb_led_pulse_stretch.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/led_pulse_stretch_if.sv
// ---------------------------------------------------------------------------
// led_pulse_stretch_if
// Groups the event/LED signals of led_pulse_stretch.
//   pulse_in : event strobe into the stretcher (one event per high cycle)
//   led      : LED drive, 1 = lit
//   busy     : stretcher is in a blink (lit or dark gap)
//   drop     : one-cycle flag, an event was discarded
//   pending  : queued blink count (only with LED_STRETCH_QUEUE_EN defined)
// Modports: master = event source / LED consumer, slave = the stretcher.
// ---------------------------------------------------------------------------
interface led_pulse_stretch_if #(
    parameter int PEND_W = 4
);
    logic pulse_in;
    logic led;
    logic busy;
    logic drop;
`ifdef LED_STRETCH_QUEUE_EN
    logic [PEND_W-1:0] pending;

    modport master (output pulse_in, input led, input busy, input drop, input pending);
    modport slave  (input pulse_in, output led, output busy, output drop, output pending);
`else
    modport master (output pulse_in, input led, input busy, input drop);
    modport slave  (input pulse_in, output led, output busy, output drop);
`endif
endinterface

// File: rtl/led_pulse_stretch.sv
// ---------------------------------------------------------------------------
// led_pulse_stretch
// Turns single-cycle event pulses into human-visible LED blinks: each
// accepted event lights the LED for ON_TICKS ticks, followed by a dark gap
// of OFF_TICKS ticks. A tick is TICK_DIV clock cycles.
//
// Ports:
//   CLK  : clock, all logic on posedge
//   RST  : synchronous active-high reset
//   io   : led_pulse_stretch_if.slave (pulse_in in; led, busy, drop,
//          and pending when queued, out; all outputs registered)
//
// Build option: define LED_STRETCH_QUEUE_EN to queue events that arrive
// during a blink (up to 2^PEND_W-1) and replay them as further blinks.
// Without it, such events are dropped.
//
// state | meaning
// IDLE  | LED dark, ready to accept an event
// ON    | LED lit for ON_TICKS ticks
// OFF   | dark gap for OFF_TICKS ticks before the next blink or IDLE
// ---------------------------------------------------------------------------
module led_pulse_stretch #(
    parameter int TICK_DIV  = 65536,
    parameter int ON_TICKS  = 8,
    parameter int OFF_TICKS = 8,
    parameter int PEND_W    = 4
) (
    input  logic                CLK,
    input  logic                RST,
    led_pulse_stretch_if.slave  io
);

    if (TICK_DIV < 2 || TICK_DIV > 65536 || ON_TICKS < 1 || ON_TICKS > 255 ||
        OFF_TICKS < 1 || OFF_TICKS > 255 || PEND_W < 1) begin : g_bad_param
        $error("led_pulse_stretch: parameter out of range");
    end

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
    localparam logic [7:0]  ON_LAST  = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST = 8'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pre_q;
    logic [7:0]  ph_q;
    logic        led_q, busy_q, drop_q;
    logic        drop_d;
    logic        tick;
    logic        off_exit;
    logic        want_next;

    assign tick     = (pre_q == PRE_LAST);
    assign off_exit = (state_q == S_OFF) && tick && (ph_q == OFF_LAST);

`ifdef LED_STRETCH_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q, pend_d;

    assign want_next = (pend_q != '0) || io.pulse_in;

    // At the OFF-exit cycle a queued blink is consumed; a same-cycle event
    // either starts the blink itself (empty queue) or replaces the consumed
    // entry (non-empty queue), so it never counts against saturation there.
    always_comb begin
        pend_d = pend_q;
        drop_d = 1'b0;
        if (off_exit) begin
            if (pend_q != '0 && !io.pulse_in) begin
                pend_d = pend_q - PEND_W'(1);
            end
        end else if (state_q != S_IDLE && io.pulse_in) begin
            if (pend_q == PEND_MAX) begin
                drop_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign io.pending = pend_q;
`else
    assign want_next = io.pulse_in;

    always_comb begin
        drop_d = 1'b0;
        if (state_q != S_IDLE && !off_exit && io.pulse_in) begin
            drop_d = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (io.pulse_in) begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (tick && ph_q == ON_LAST) begin
                    state_d = S_OFF;
                end
            end
            S_OFF: begin
                if (off_exit) begin
                    state_d = want_next ? S_ON : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Prescaler and phase timer restart on every state change so each
    // phase lasts an exact whole number of ticks from its first cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            ph_q    <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                pre_q <= '0;
                ph_q  <= '0;
            end else if (state_q != S_IDLE) begin
                if (tick) begin
                    pre_q <= '0;
                    ph_q  <= ph_q + 8'd1;
                end else begin
                    pre_q <= pre_q + 16'd1;
                end
            end
            led_q  <= (state_d == S_ON);
            busy_q <= (state_d != S_IDLE);
            drop_q <= drop_d;
        end
    end

    assign io.led  = led_q;
    assign io.busy = busy_q;
    assign io.drop = drop_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Bench for led_pulse_stretch with TICK_DIV=4, ON_TICKS=2, OFF_TICKS=1,
// PEND_W=2 (ON = 8 cycles, OFF = 4 cycles). Works with or without
// LED_STRETCH_QUEUE_EN defined.
module tb_led_pulse_stretch;

    localparam int DIV    = 4;
    localparam int ON_T   = 2;
    localparam int OFF_T  = 1;
    localparam int PW     = 2;
    localparam int ON_CYC = ON_T * DIV;
    localparam int PERIOD = (ON_T + OFF_T) * DIV;
    localparam int PMAX   = (1 << PW) - 1;
`ifdef LED_STRETCH_QUEUE_EN
    localparam bit QUEUE = 1'b1;
`else
    localparam bit QUEUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_pulse_stretch_if #(.PEND_W(PW)) io ();

    led_pulse_stretch #(
        .TICK_DIV (DIV),
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .PEND_W   (PW)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .io (io)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: a blink is a window of PERIOD cycles measured by its
    // age; the LED is lit for the first ON_CYC cycles of the window.
    bit m_act;
    int m_age;
    int m_pend;
    bit m_drop;

    logic obs_led  [0:127];
    logic obs_busy [0:127];
    logic obs_drop [0:127];
    int   obs_pend [0:127];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_step(input bit p, input bit r);
        m_drop = 1'b0;
        if (r) begin
            m_act  = 1'b0;
            m_age  = 0;
            m_pend = 0;
        end else if (!m_act) begin
            if (p) begin
                m_act = 1'b1;
                m_age = 0;
            end
        end else if (m_age == PERIOD - 1) begin
            if (m_pend > 0 || p) begin
                m_age = 0;
                if (m_pend > 0 && !p) m_pend--;
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_age++;
            if (p) begin
                if (QUEUE && m_pend < PMAX) m_pend++;
                else m_drop = 1'b1;
            end
        end
    endtask

    task automatic step(input bit p, input bit r);
        @(negedge clk);
        io.pulse_in = p;
        rst         = r;
        model_step(p, r);
        @(posedge clk);
        #1;
        chk("led",  32'(io.led),  32'(m_act && m_age < ON_CYC));
        chk("busy", 32'(io.busy), 32'(m_act));
        chk("drop", 32'(io.drop), 32'(m_drop));
`ifdef LED_STRETCH_QUEUE_EN
        chk("pending", 32'(io.pending), 32'(m_pend));
`endif
        cyc++;
    endtask

    task automatic record(input int k);
        obs_led[k]  = io.led;
        obs_busy[k] = io.busy;
        obs_drop[k] = io.drop;
`ifdef LED_STRETCH_QUEUE_EN
        obs_pend[k] = int'(io.pending);
`else
        obs_pend[k] = 0;
`endif
    endtask

    // Three reset cycles, then cycles 0..n-1 with pulse/reset masks.
    // obs_*[k] hold the outputs seen in cycle k (index 0 = first cycle
    // after reset release).
    task automatic run_pattern(input logic [127:0] pm, input logic [127:0] rm, input int n);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        record(0);
        for (int k = 0; k < n; k++) begin
            step(pm[k], rm[k]);
            record(k + 1);
        end
    endtask

    logic [127:0] pm, rm;
    int dens;

    initial begin
        rst         = 1'b1;
        io.pulse_in = 1'b0;
        m_act = 1'b0; m_age = 0; m_pend = 0; m_drop = 1'b0;

        // 1: reset values and a single event
        pm = '0; rm = '0; pm[10] = 1'b1;
        run_pattern(pm, rm, 30);
        chk("s1_rst_led",  32'(obs_led[0]),  32'd0);
        chk("s1_rst_busy", 32'(obs_busy[0]), 32'd0);
        chk("s1_rst_drop", 32'(obs_drop[0]), 32'd0);
        chk("s1_rst_pend", 32'(obs_pend[0]), 32'd0);
        chk("s1_led10",  32'(obs_led[10]),  32'd0);
        chk("s1_led11",  32'(obs_led[11]),  32'd1);
        chk("s1_led18",  32'(obs_led[18]),  32'd1);
        chk("s1_led19",  32'(obs_led[19]),  32'd0);
        chk("s1_busy22", 32'(obs_busy[22]), 32'd1);
        chk("s1_busy23", 32'(obs_busy[23]), 32'd0);

        // 2: burst during a blink
        pm = '0; pm[10] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1;
        run_pattern(pm, rm, 50);
`ifdef LED_STRETCH_QUEUE_EN
        chk("s2_pend14", 32'(obs_pend[14]), 32'd2);
        chk("s2_led23",  32'(obs_led[23]),  32'd1);
        chk("s2_led34",  32'(obs_led[34]),  32'd0);
        chk("s2_led35",  32'(obs_led[35]),  32'd1);
        chk("s2_busy46", 32'(obs_busy[46]), 32'd1);
        chk("s2_busy47", 32'(obs_busy[47]), 32'd0);
        chk("s2_drop14", 32'(obs_drop[14]), 32'd0);
`else
        chk("s2_drop13", 32'(obs_drop[13]), 32'd1);
        chk("s2_drop14", 32'(obs_drop[14]), 32'd1);
        chk("s2_busy23", 32'(obs_busy[23]), 32'd0);
`endif

        // 3: saturation
        pm = '0; pm[10] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1; pm[14] = 1'b1; pm[15] = 1'b1;
        run_pattern(pm, rm, 40);
`ifdef LED_STRETCH_QUEUE_EN
        chk("s3_drop15", 32'(obs_drop[15]), 32'd0);
        chk("s3_drop16", 32'(obs_drop[16]), 32'd1);
        chk("s3_drop17", 32'(obs_drop[17]), 32'd0);
        chk("s3_pend16", 32'(obs_pend[16]), 32'd3);
`endif

        // 4: drop in ON, consume at OFF exit
        pm = '0; pm[10] = 1'b1; pm[14] = 1'b1; pm[22] = 1'b1;
        run_pattern(pm, rm, 40);
`ifndef LED_STRETCH_QUEUE_EN
        chk("s4_drop15", 32'(obs_drop[15]), 32'd1);
        chk("s4_led23",  32'(obs_led[23]),  32'd1);
        chk("s4_drop23", 32'(obs_drop[23]), 32'd0);
`endif

        // 5: reset mid-blink
        pm = '0; pm[10] = 1'b1; pm[20] = 1'b1; rm[15] = 1'b1;
        run_pattern(pm, rm, 40);
        chk("s5_led16",  32'(obs_led[16]),  32'd0);
        chk("s5_busy16", 32'(obs_busy[16]), 32'd0);
        chk("s5_pend16", 32'(obs_pend[16]), 32'd0);
        chk("s5_led21",  32'(obs_led[21]),  32'd1);
        chk("s5_led28",  32'(obs_led[28]),  32'd1);
        chk("s5_led29",  32'(obs_led[29]),  32'd0);
        rm = '0;

        // 6: saturated queue plus event at the OFF-exit cycle
        pm = '0; pm[10] = 1'b1; pm[12] = 1'b1; pm[13] = 1'b1; pm[14] = 1'b1; pm[22] = 1'b1;
        run_pattern(pm, rm, 40);
        chk("s6_led22", 32'(obs_led[22]), 32'd0);
        chk("s6_led23", 32'(obs_led[23]), 32'd1);
`ifdef LED_STRETCH_QUEUE_EN
        chk("s6_pend22", 32'(obs_pend[22]), 32'd3);
        chk("s6_pend23", 32'(obs_pend[23]), 32'd3);
        chk("s6_drop23", 32'(obs_drop[23]), 32'd0);
`endif

        // Random traffic with varying event density and rare resets
        for (int seg = 0; seg < 20; seg++) begin
            case ($urandom_range(0, 2))
                0:       dens = 2;
                1:       dens = 10;
                default: dens = 40;
            endcase
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, dens - 1) == 0, $urandom_range(0, 499) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
